// File: rtl/logicgates_bist.sv
// logicgates_bist -- sequential built-in self-test for the seven-output
// two-input logic-gate block.
//
// Drives a/b through the vectors 00, 01, 10, 11. After each vector it
// waits SETTLE_CYCLES cycles, then compares the seven gate outputs with
// internally computed expected values. Results are accumulated across
// the run.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle run request, honoured only in IDLE or DONE
//   resp[6:0]  in   gate outputs under test
//                   [0]=and [1]=or [2]=not [3]=nand [4]=nor [5]=xor [6]=xnor
//   a, b       out  registered drive to the gate inputs
//   busy       out  high while a run is in progress
//   done       out  high in DONE until the next start or reset
//   pass       out  done and err_count == 0
//   err_count  out  saturating count of mismatching response bits
//   fail_mask  out  sticky OR of mismatching response bit positions
//   vec_fail   out  bit i set if vector i had any mismatch
module logicgates_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       resp,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask,
  output logic [3:0]       vec_fail
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state_r;
  logic [1:0]       idx_r;
  logic [3:0]       settle_r;
  logic [6:0]       exp_s;
  logic [6:0]       mism_s;
  logic [2:0]       pop_s;
  logic [ERR_W-1:0] err_next_s;

  // Expected gate outputs for inputs va, vb, in resp bit order.
  function automatic logic [6:0] expected_resp(input logic va, input logic vb);
    logic [6:0] e;
    e[0] = va & vb;
    e[1] = va | vb;
    e[2] = ~va;
    e[3] = ~(va & vb);
    e[4] = ~(va | vb);
    e[5] = va ^ vb;
    e[6] = ~(va ^ vb);
    return e;
  endfunction

  // Number of set bits in a 7-bit mismatch vector.
  function automatic logic [2:0] popcount7(input logic [6:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < 7; k++) begin
      c = c + {2'b00, m[k]};
    end
    return c;
  endfunction

  // Add with saturation at all-ones; the carry bit flags overflow.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [2:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, acc} + (ERR_W+1)'(inc);
    if (sum[ERR_W]) begin
      return ERR_MAX;
    end else begin
      return sum[ERR_W-1:0];
    end
  endfunction

  // Response comparison; a non-0/1 response bit counts as a mismatch.
  always_comb begin
    exp_s  = expected_resp(a, b);
    mism_s = 7'd0;
    for (int k = 0; k < 7; k++) begin
      if (resp[k] !== exp_s[k]) begin
        mism_s[k] = 1'b1;
      end else begin
        mism_s[k] = 1'b0;
      end
    end
    pop_s      = popcount7(mism_s);
    err_next_s = sat_add(err_count, pop_s);
  end

  // Test sequencer with registered drive and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      idx_r     <= 2'd0;
      settle_r  <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= 7'd0;
      vec_fail  <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          // DONE holds the last vector and results until a new start.
          if (start) begin
            state_r   <= S_APPLY;
            idx_r     <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= 7'd0;
            vec_fail  <= 4'd0;
          end else begin
            state_r <= state_r;
          end
        end
        S_APPLY: begin
          if (SETTLE_LD == 4'd0) begin
            state_r <= S_CHECK;
          end else begin
            settle_r <= SETTLE_LD;
            state_r  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter was loaded with SETTLE_CYCLES; leaving at 1 gives
          // exactly SETTLE_CYCLES cycles in this state.
          settle_r <= settle_r - 4'd1;
          if (settle_r == 4'd1) begin
            state_r <= S_CHECK;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_CHECK: begin
          err_count       <= err_next_s;
          fail_mask       <= fail_mask | mism_s;
          vec_fail[idx_r] <= |mism_s;
          if (idx_r == 2'd3) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == '0);
          end else begin
            idx_r   <= idx_r + 2'd1;
            {a, b}  <= idx_r + 2'd1;
            state_r <= S_APPLY;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logicgates_bist.sv
// Directed bench for logicgates_bist. Three instances share clock and
// reset: dut0 (defaults, selectable fault model), dut1 (ERR_W=4, always
// inverted responses) and dut2 (SETTLE_CYCLES=0, optional x on and_y in
// vector 3). Expected responses come from a hand-written truth table.
module tb_logicgates_bist;

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic       a0, b0, busy0, done0, pass0;
  logic [4:0] err0;
  logic [6:0] mask0, resp0;
  logic [3:0] vec0;

  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [6:0] mask1, resp1;
  logic [3:0] vec1;

  logic       a2, b2, busy2, done2, pass2;
  logic [4:0] err2;
  logic [6:0] mask2, resp2;
  logic [3:0] vec2;

  int   mode0;
  logic xflag;
  int   errors = 0;
  int   checks = 0;

  // Truth table, bits [6:0] = xnor xor nor nand not or and, index {a,b}.
  logic [6:0] good_tab [4] = '{7'h5C, 7'h2E, 7'h2A, 7'h43};

  always #5 clk = ~clk;

  logicgates_bist dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0), .vec_fail(vec0)
  );

  logicgates_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1), .vec_fail(vec1)
  );

  logicgates_bist #(.SETTLE_CYCLES(0), .ERR_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_mask(mask2), .vec_fail(vec2)
  );

  // Gate-block models feeding each instance.
  always_comb begin
    resp0 = good_tab[{a0, b0}];
    case (mode0)
      1:       resp0[5] = 1'b0;
      2:       resp0 = ~good_tab[{a0, b0}];
      default: resp0 = good_tab[{a0, b0}];
    endcase
    resp1 = ~good_tab[{a1, b1}];
    resp2 = good_tab[{a2, b2}];
    if (xflag && a2 && b2) begin
      resp2[0] = 1'bx;
    end else begin
      resp2[0] = good_tab[{a2, b2}][0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One run: start sampled at edge E0+1; k counts edges after E0.
  // pulse_edge (0 = none) places an extra start sample at that edge.
  task automatic run_vectors(input string tag, input int pulse_edge,
                             input logic [4:0] e0_err, input logic [6:0] e0_mask,
                             input logic [3:0] e0_vec, input logic [4:0] e2_err,
                             input logic [3:0] e2_vec);
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      start = (k + 1 == pulse_edge) ? 1'b1 : 1'b0;
      if (k == 1) begin
        check({tag, ":busy_rise"}, busy0, 1);
        check({tag, ":done_drop"}, done0, 0);
        check({tag, ":ab0"}, {a0, b0}, 0);
      end
      if (k == 5 || k == 9 || k == 13) begin
        check({tag, ":ab_step"}, {a0, b0}, (k - 1) / 4);
      end
      if (k == 8) begin
        check({tag, ":s0_done_early"}, done2, 0);
      end
      if (k == 9) begin
        check({tag, ":s0_done"}, done2, 1);
        check({tag, ":s0_err"}, err2, e2_err);
        check({tag, ":s0_vec"}, vec2, e2_vec);
        check({tag, ":s0_pass"}, pass2, (e2_err == 5'd0) ? 1 : 0);
      end
      if (k == 16) begin
        check({tag, ":done_early"}, done0, 0);
        check({tag, ":busy_late"}, busy0, 1);
      end
      if (k == 17) begin
        check({tag, ":done"}, done0, 1);
        check({tag, ":busy_end"}, busy0, 0);
        check({tag, ":pass"}, pass0, (e0_err == 5'd0) ? 1 : 0);
        check({tag, ":err"}, err0, e0_err);
        check({tag, ":mask"}, mask0, e0_mask);
        check({tag, ":vec"}, vec0, e0_vec);
        check({tag, ":w4_err"}, err1, 15);
        check({tag, ":w4_mask"}, mask1, 7'h7F);
        check({tag, ":w4_vec"}, vec1, 4'hF);
        check({tag, ":w4_pass"}, {done1, pass1}, 2'b10);
      end
      if (k == 18) begin
        check({tag, ":done_hold"}, {done0, busy0, a0, b0}, 4'b1011);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode0 = 0;
    xflag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut0", {a0, b0, busy0, done0, pass0, err0, mask0, vec0}, 0);
    check("reset_dut2", {a2, b2, busy2, done2, pass2, err2, mask2, vec2}, 0);
    rst_n = 1'b1;

    xflag = 1'b1;
    run_vectors("good", 0, 5'd0, 7'h00, 4'h0, 5'd1, 4'b1000);

    xflag = 1'b0;
    mode0 = 1;
    run_vectors("xor_stuck", 0, 5'd2, 7'h20, 4'b0110, 5'd0, 4'h0);

    mode0 = 2;
    run_vectors("inverted", 0, 5'd28, 7'h7F, 4'hF, 5'd0, 4'h0);

    mode0 = 0;
    run_vectors("start_in_wait", 7, 5'd0, 7'h00, 4'h0, 5'd0, 4'h0);
    run_vectors("start_at_check", 17, 5'd0, 7'h00, 4'h0, 5'd0, 4'h0);

    // Abort a run during vector 2 with a one-cycle reset.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_vec2", {a0, b0, busy0}, 3'b101);
    rst_n = 1'b0;
    #1;
    check("abort_reset", {a0, b0, busy0, done0, pass0, err0, mask0, vec0}, 0);
    check("abort_reset_w4", {busy1, err1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vectors("after_reset", 0, 5'd0, 7'h00, 4'h0, 5'd0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logicgates_bist.md
Name: logicgates_bist

Overview:
- Sequential built-in self-test for the seven-output two-input logic-gate block.
- Sits on the drive side of the gate block. It drives `a` and `b` through the four input combinations, waits for outputs to settle, then compares all seven gate outputs against internally computed expected values.
- Reports per-vector and per-gate failures, a saturating mismatch count, and a pass/done status.
- Used as the hardware counterpart of the directed gate bench, for on-chip and regression checking.

Parameters:
- SETTLE_CYCLES, 2: idle cycles between driving a vector and sampling the response. Legal range 0..15.
- ERR_W, 5: width of err_count. 5 covers the maximum of 28 mismatching bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request. Sampled only in IDLE or DONE.
- resp  input  7  gate outputs under test: [0]=and_y [1]=or_y [2]=not_y [3]=nand_y [4]=nor_y [5]=xor_y [6]=xnor_y.
- a  output  1  registered drive to gate input a.
- b  output  1  registered drive to gate input b.
- busy  output  1  high in APPLY, WAIT and CHECK.
- done  output  1  level, high in DONE until the next start or reset.
- pass  output  1  done AND err_count==0.
- err_count  output  ERR_W  total mismatching response bits in the run. Saturates at all-ones.
- fail_mask  output  7  sticky OR of mismatching resp bit positions over the run.
- vec_fail  output  4  bit i set if vector i had any mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, a=b=0, vector index=0, settle counter=0; busy=done=pass=0; err_count=0, fail_mask=0, vec_fail=0.
- Vector order, with index i = {a,b}: 00, 01, 10, 11.
- Expected values:
  - and=a&b, or=a|b, not=~a
  - nand=~(a&b), nor=~(a|b)
  - xor=a^b, xnor=~(a^b)
- IDLE:
  - start=1 → APPLY.
  - On the same edge: index=0; err_count, fail_mask and vec_fail cleared; a,b ← vector 0.
- APPLY (1 cycle): load settle counter with SETTLE_CYCLES → WAIT, or → CHECK if SETTLE_CYCLES=0.
- WAIT: decrement each cycle; when the counter reaches 1 → CHECK. WAIT lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - mism = resp compared bitwise against expected.
  - Any resp bit not a clean 0/1 counts as a mismatch (case-inequality in simulation).
  - err_count += popcount(mism), saturating.
  - fail_mask |= mism.
  - vec_fail[i] = |mism.
  - If i==3 → DONE; else i++, a,b ← next vector, → APPLY.
- DONE:
  - a,b hold the last vector.
  - start=1 restarts exactly as from IDLE: results are cleared and done drops on the same edge.
- Cycle counts:
  - Each vector takes 2+SETTLE_CYCLES cycles.
  - done rises at edge 4·(2+SETTLE_CYCLES)+1 after the start edge. This is edge 17 with the default.
- start while busy: ignored, no restart, no effect on results.
- start coincident with the final CHECK: ignored; DONE is entered normally.
- Reset mid-run: immediate return to the reset state; partial results are discarded.
- resp is sampled only in CHECK. Changes on resp in other states have no effect.
- err_count saturation: with ERR_W small enough that 28 exceeds the max, hold at 2^ERR_W−1; no wrap.

Test Plan:
- Correct gate model, default params, start pulse:
  - busy rises on the edge after start; a,b step 00,01,10,11 every 4 cycles.
  - done=1, pass=1, err_count=0, fail_mask=0, vec_fail=0 at edge 17.
- xor_y stuck at 0:
  - err_count=2, fail_mask=7'h20, vec_fail=4'b0110, pass=0.
- All resp bits inverted:
  - err_count=28, fail_mask=7'h7F, vec_fail=4'hF.
  - Same with ERR_W=4: err_count=15 (saturated).
- start pulsed during WAIT of vector 1:
  - No restart; run completes on the original schedule with correct results.
- rst_n low for 1 cycle during vector 2, then start:
  - Outputs return to reset values asynchronously.
  - Fresh run completes with correct-model results.
- SETTLE_CYCLES=0, correct model, plus one resp bit forced to x during vector 3:
  - done at edge 9.
  - err_count=1, vec_fail=4'b1000.
  - Then a second start from DONE clears results and reruns cleanly to pass=1.
